// File: rtl/led_pio_arbiter.sv
// led_pio_arbiter: two-requester round-robin arbiter sequencing single commands onto the LED PIO slave
module led_pio_arbiter #(
  parameter int ADDR_W = 2,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  input  logic              req0_write,
  input  logic [ADDR_W-1:0] req0_address,
  input  logic [DATA_W-1:0] req0_writedata,
  output logic              req0_done,
  output logic [DATA_W-1:0] req0_readdata,
  input  logic              req1_valid,
  input  logic              req1_write,
  input  logic [ADDR_W-1:0] req1_address,
  input  logic [DATA_W-1:0] req1_writedata,
  output logic              req1_done,
  output logic [DATA_W-1:0] req1_readdata,
  output logic              pio_chipselect,
  output logic              pio_write_n,
  output logic [ADDR_W-1:0] pio_address,
  output logic [DATA_W-1:0] pio_writedata,
  input  logic [DATA_W-1:0] pio_readdata,
  output logic              grant
);
  typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;
  state_t state, state_nxt;
  logic last_grant, last_grant_nxt, grant_nxt, win;
  logic cs_nxt, wn_nxt, done0_nxt, done1_nxt;
  logic [ADDR_W-1:0] addr_nxt;
  logic [DATA_W-1:0] wd_nxt, rd0_nxt, rd1_nxt;
  always_comb begin
    win = (req0_valid & req1_valid) ? ~last_grant : req1_valid;
    state_nxt = state;
    last_grant_nxt = last_grant;
    grant_nxt = grant;
    cs_nxt = pio_chipselect;
    wn_nxt = pio_write_n;
    addr_nxt = pio_address;
    wd_nxt = pio_writedata;
    done0_nxt = 1'b0;
    done1_nxt = 1'b0;
    rd0_nxt = req0_readdata;
    rd1_nxt = req1_readdata;
    case (state)
      IDLE: if (req0_valid | req1_valid) begin
        state_nxt = ISSUE;
        grant_nxt = win;
        cs_nxt = 1'b1;
        wn_nxt = ~(win ? req1_write : req0_write);
        addr_nxt = win ? req1_address : req0_address;
        wd_nxt = win ? req1_writedata : req0_writedata;
      end
      ISSUE: begin
        state_nxt = DONE;
        cs_nxt = 1'b0;
        wn_nxt = 1'b1;
        last_grant_nxt = grant;
        done0_nxt = ~grant;
        done1_nxt = grant;
        rd0_nxt = (pio_write_n & ~grant) ? pio_readdata : req0_readdata;
        rd1_nxt = (pio_write_n & grant) ? pio_readdata : req1_readdata;
      end
      default: state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      last_grant <= 1'b1;
      grant <= 1'b0;
      pio_chipselect <= 1'b0;
      pio_write_n <= 1'b1;
      pio_address <= '0;
      pio_writedata <= '0;
      req0_done <= 1'b0;
      req1_done <= 1'b0;
      req0_readdata <= '0;
      req1_readdata <= '0;
    end else begin
      state <= state_nxt;
      last_grant <= last_grant_nxt;
      grant <= grant_nxt;
      pio_chipselect <= cs_nxt;
      pio_write_n <= wn_nxt;
      pio_address <= addr_nxt;
      pio_writedata <= wd_nxt;
      req0_done <= done0_nxt;
      req1_done <= done1_nxt;
      req0_readdata <= rd0_nxt;
      req1_readdata <= rd1_nxt;
    end
  end
endmodule

// File: tb/tb_led_pio_arbiter.sv
// tb_led_pio_arbiter: directed self-checking bench with an 18-bit LED PIO model on the slave side
module tb_led_pio_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic req0_valid = 1'b0, req0_write = 1'b0, req1_valid = 1'b0, req1_write = 1'b0;
  logic [1:0] req0_address = '0, req1_address = '0, pio_address;
  logic [31:0] req0_writedata = '0, req1_writedata = '0;
  logic req0_done, req1_done, pio_chipselect, pio_write_n, grant;
  logic [31:0] req0_readdata, req1_readdata, pio_writedata, pio_readdata;
  logic [17:0] out_port = '0;
  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  led_pio_arbiter #(.ADDR_W(2), .DATA_W(32)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_write(req0_write), .req0_address(req0_address),
    .req0_writedata(req0_writedata), .req0_done(req0_done), .req0_readdata(req0_readdata),
    .req1_valid(req1_valid), .req1_write(req1_write), .req1_address(req1_address),
    .req1_writedata(req1_writedata), .req1_done(req1_done), .req1_readdata(req1_readdata),
    .pio_chipselect(pio_chipselect), .pio_write_n(pio_write_n), .pio_address(pio_address),
    .pio_writedata(pio_writedata), .pio_readdata(pio_readdata), .grant(grant)
  );

  assign pio_readdata = (pio_address == 2'd0) ? {14'd0, out_port} : 32'd0;
  always @(posedge clk)
    if (pio_chipselect && !pio_write_n && pio_address == 2'd0) out_port <= pio_writedata[17:0];

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    step();
    reset = 1'b0;
  endtask

  task automatic cmd(input bit p, input bit wr, input logic [1:0] a, input logic [31:0] d,
                     output logic [31:0] rd);
    bit got = 0;
    rd = '0;
    if (p) begin
      req1_valid = 1'b1; req1_write = wr; req1_address = a; req1_writedata = d;
    end else begin
      req0_valid = 1'b1; req0_write = wr; req0_address = a; req0_writedata = d;
    end
    for (int i = 0; i < 10 && !got; i++) begin
      step();
      if (p ? req1_done : req0_done) begin
        got = 1;
        rd = p ? req1_readdata : req0_readdata;
      end
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    chk("cmd_done_seen", 32'(got), 32'd1);
  endtask

  initial begin
    logic [31:0] rd;
    int pulses;
    logic prev_cs;
    step();
    do_reset();
    chk("rst_cs", 32'(pio_chipselect), 32'd0);
    chk("rst_wn", 32'(pio_write_n), 32'd1);
    chk("rst_addr", 32'(pio_address), 32'd0);
    chk("rst_wd", pio_writedata, 32'd0);
    chk("rst_done", {30'd0, req1_done, req0_done}, 32'd0);
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_rd0", req0_readdata, 32'd0);

    // single write
    req0_valid = 1'b1; req0_write = 1'b1; req0_address = 2'd0; req0_writedata = 32'h0002AAAA;
    step();
    chk("sw_c1_cs", 32'(pio_chipselect), 32'd1);
    chk("sw_c1_wn", 32'(pio_write_n), 32'd0);
    chk("sw_c1_wd", pio_writedata, 32'h0002AAAA);
    chk("sw_c1_grant", 32'(grant), 32'd0);
    chk("sw_c1_done", 32'(req0_done), 32'd0);
    req0_valid = 1'b0;
    step();
    chk("sw_c2_cs", 32'(pio_chipselect), 32'd0);
    chk("sw_c2_wn", 32'(pio_write_n), 32'd1);
    chk("sw_c2_done0", 32'(req0_done), 32'd1);
    chk("sw_c2_done1", 32'(req1_done), 32'd0);
    chk("sw_out_port", 32'(out_port), 32'h2AAAA);
    step();
    chk("sw_c3_done0", 32'(req0_done), 32'd0);

    // contention alternation from reset
    do_reset();
    req0_valid = 1'b1; req0_write = 1'b1; req0_address = 2'd0; req0_writedata = 32'h1;
    req1_valid = 1'b1; req1_write = 1'b1; req1_address = 2'd0; req1_writedata = 32'h2;
    for (int k = 1; k <= 9; k++) begin
      step();
      chk($sformatf("ct_c%0d_cs", k), 32'(pio_chipselect), 32'(k % 3 == 1));
      chk($sformatf("ct_c%0d_done0", k), 32'(req0_done), 32'(k == 2 || k == 8));
      chk($sformatf("ct_c%0d_done1", k), 32'(req1_done), 32'(k == 5));
      chk($sformatf("ct_c%0d_grant", k), 32'(grant), 32'(k >= 4 && k <= 6));
      chk($sformatf("ct_c%0d_wd", k), pio_writedata, (k >= 4 && k <= 6) ? 32'h2 : 32'h1);
      if (k == 2 || k == 8) chk($sformatf("ct_c%0d_out", k), 32'(out_port), 32'h1);
      if (k == 5) chk("ct_c5_out", 32'(out_port), 32'h2);
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    step();

    // read routing
    cmd(1'b0, 1'b1, 2'd0, 32'h0003FFFF, rd);
    chk("rr_out_port", 32'(out_port), 32'h3FFFF);
    cmd(1'b1, 1'b0, 2'd0, 32'h0, rd);
    chk("rr_rd1_a0", rd, 32'h0003FFFF);
    chk("rr_rd0_kept", req0_readdata, 32'd0);
    cmd(1'b1, 1'b0, 2'd1, 32'h0, rd);
    chk("rr_rd1_a1", rd, 32'h0);
    cmd(1'b0, 1'b1, 2'd0, 32'h00011111, rd);
    chk("rr_rd1_after_wr", req1_readdata, 32'h0);
    chk("rr_rd0_after_wr", req0_readdata, 32'd0);
    cmd(1'b0, 1'b0, 2'd0, 32'h0, rd);
    chk("rr_rd0_a0", rd, 32'h00011111);

    // lone requester after reset (last_grant = 1)
    do_reset();
    req1_valid = 1'b1; req1_write = 1'b0; req1_address = 2'd0;
    pulses = 0;
    prev_cs = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      step();
      if (req1_done) pulses++;
      chk($sformatf("lone_c%0d_cs", k), 32'(pio_chipselect), 32'(k % 3 == 1));
      chk($sformatf("lone_c%0d_done0", k), 32'(req0_done), 32'd0);
      if (prev_cs) chk("lone_cs_once", 32'(pio_chipselect), 32'd0);
      prev_cs = pio_chipselect;
    end
    req1_valid = 1'b0;
    chk("lone_pulses", 32'(pulses), 32'd3);
    chk("lone_grant", 32'(grant), 32'd1);
    step();

    // reset during ISSUE
    req0_valid = 1'b1; req0_write = 1'b1; req0_address = 2'd0; req0_writedata = 32'h00012345;
    step();
    chk("ri_c1_cs", 32'(pio_chipselect), 32'd1);
    reset = 1'b1;
    req0_valid = 1'b0;
    step();
    reset = 1'b0;
    chk("ri_out_port", 32'(out_port), 32'h12345);
    chk("ri_cs", 32'(pio_chipselect), 32'd0);
    chk("ri_done0", 32'(req0_done), 32'd0);
    chk("ri_wn", 32'(pio_write_n), 32'd1);
    chk("ri_addr", 32'(pio_address), 32'd0);
    chk("ri_wd", pio_writedata, 32'd0);
    step();
    chk("ri_done0_next", 32'(req0_done), 32'd0);
    chk("ri_cs_next", 32'(pio_chipselect), 32'd0);

    // idle
    for (int k = 0; k < 20; k++) begin
      step();
      chk($sformatf("idle_%0d", k), {29'd0, pio_chipselect, req1_done, req0_done}, 32'd0);
    end
    chk("idle_wn", 32'(pio_write_n), 32'd1);
    chk("idle_wd", pio_writedata, 32'd0);
    chk("idle_rd", req0_readdata | req1_readdata, 32'd0);
    chk("idle_grant", 32'(grant), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/led_pio_arbiter.md
Name: led_pio_arbiter

Overview:
- Two-requester round-robin arbiter for the 18-bit red-LED PIO Avalon slave (s1).
- Lets two independent agents share one PIO, e.g. the Nios-side bridge and a hardware status/blink engine.
- Each requester issues single read or write commands through a valid/done handshake. The block sequences each granted command into exactly one zero-wait-state PIO access.
- Read data is returned to the granted requester only.

Parameters:
- ADDR_W, 2, PIO address width.
- DATA_W, 32, Avalon data width on both requester and PIO sides.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- req0_valid  in  1  requester 0 command pending; held until req0_done.
- req0_write  in  1  1 = write, 0 = read.
- req0_address  in  ADDR_W  PIO register address.
- req0_writedata  in  DATA_W  write data.
- req0_done  out  1  one-cycle pulse: command completed.
- req0_readdata  out  DATA_W  read result, valid with req0_done.
- req1_valid, req1_write, req1_address, req1_writedata, req1_done, req1_readdata: same as requester 0.
- pio_chipselect  out  1  PIO chipselect.
- pio_write_n  out  1  PIO active-low write strobe.
- pio_address  out  ADDR_W  PIO address.
- pio_writedata  out  DATA_W  PIO write data.
- pio_readdata  in  DATA_W  PIO read data; combinational from pio_address, zero wait states.
- grant  out  1  index of the requester owning the current or last transaction.

Behaviour:
- Interface:
  - One clock: clk. Reset is synchronous and active-high: reset.
  - All outputs are registered.
- Reset values:
  - State IDLE.
  - pio_chipselect = 0, pio_write_n = 1, pio_address = 0, pio_writedata = 0.
  - req0_done = req1_done = 0, req0_readdata = req1_readdata = 0.
  - grant = 0. Internal last_grant = 1, so requester 0 wins the first contention.
- FSM states: IDLE -> ISSUE -> DONE -> IDLE.
- IDLE:
  - If no valid is asserted, stay in IDLE.
  - If exactly one valid is asserted, grant that requester.
  - If both are asserted, grant ~last_grant.
  - On the grant edge:
    - Latch that requester's write/address/writedata into pio_address/pio_writedata.
    - Set pio_chipselect = 1 and pio_write_n = ~write.
    - Set grant = winner.
    - Go to ISSUE.
- ISSUE (exactly one cycle, PIO access cycle):
  - On the exiting edge the PIO samples the write, if any.
  - For reads, capture pio_readdata into reqG_readdata.
  - Clear pio_chipselect = 0 and pio_write_n = 1. Address and writedata hold.
  - Assert reqG_done = 1, set last_grant = grant, go to DONE.
- DONE (one cycle):
  - reqG_done is high this cycle; it clears on the exiting edge.
  - Valids are not sampled in DONE. Go to IDLE.
- Latency: valid sampled at edge N; PIO access during cycle N+1; done high during cycle N+2. Throughput is one command per 3 cycles.
- Requester rules:
  - Command fields must be stable while valid is high.
  - Keeping valid high after done means a new command, sampled in the following IDLE cycle.
- Fairness:
  - Under continuous contention, grants alternate strictly 0,1,0,1.
  - A lone requester is granted every 3 cycles regardless of last_grant.
- readdata:
  - Updated only by a read granted to that port.
  - Writes and the other port's reads leave it unchanged.
- Addresses are passed through unchecked; the PIO decodes them.
- The non-granted port's done stays 0 and its command waits.
- Reset mid-operation:
  - Sync reset at any edge returns to the reset values. The in-flight command is dropped and no done is issued.
  - If reset is asserted at the ISSUE-exiting edge, the PIO still captures the write on that edge, but done is suppressed.
  - A requester must reissue after reset.
- pio_chipselect is never high for more than one consecutive cycle, and never high in IDLE or DONE.

Test Plan:
- Single write: after reset, req0 write addr 0 data 0x0002AAAA, valid at cycle 0 -> pio_chipselect = 1 and pio_write_n = 0 in cycle 1 only; req0_done in cycle 2; PIO out_port = 0x2AAAA; grant = 0.
- Contention alternation: req0 and req1 both write (0x00001, 0x00002) continuously from reset -> PIO writes in order 0x00001, 0x00002, 0x00001 at cycles 1, 4, 7; done pulses at cycles 2, 5, 8 on ports 0, 1, 0.
- Read routing: after writing 0x3FFFF, req1 reads addr 0 -> req1_readdata = 0x0003FFFF with req1_done; req0_readdata stays 0. req1 reads addr 1 -> req1_readdata = 0x00000000.
- Lone requester: req1 valid alone for 9 cycles with last_grant = 1 -> granted at cycles 0, 3, 6; 3 done pulses.
- Reset during ISSUE: req0 write 0x12345, reset high for the cycle-1 edge -> state IDLE, no req0_done, chipselect = 0 next cycle; bench checks PIO capture per the edge rule.
- Idle check: no valids for 20 cycles -> pio_chipselect, req0_done and req1_done stay 0; outputs hold reset values.
